// File: rtl/spi_pkg.sv
// Shared constants and state encodings for the SPI slave front end.
package spi_pkg;

   localparam int unsigned FRAME_W_DEF = 10;
   localparam int unsigned DATA_W_DEF  = 8;
   localparam int unsigned CNT_W       = 4;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CHK_CMD   = 3'd1;
   localparam logic [2:0] ST_WRITE     = 3'd2;
   localparam logic [2:0] ST_READ_ADD  = 3'd3;
   localparam logic [2:0] ST_READ_DATA = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      CHK_CMD   = ST_CHK_CMD,
      WRITE     = ST_WRITE,
      READ_ADD  = ST_READ_ADD,
      READ_DATA = ST_READ_DATA
   } state_t;

   // Progress within a frame-carrying state: shifting in, read-data
   // handshake (rx_valid cycle, guard cycle, wait for tx_valid, shift out),
   // then idle until ss_n rises.
   typedef enum logic [2:0] {
      PH_FRAME,
      PH_RXV,
      PH_GUARD,
      PH_WAIT_TX,
      PH_SHIFT,
      PH_HOLD
   } phase_t;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises MOSI command frames for the RAM and serialises
// read data back on MISO, MSB first.
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned FRAME_W = FRAME_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ss_n,
   input  logic               mosi,
   output logic               miso,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid
);

   state_t             state;
   phase_t             phase;
   logic               rd_addr_seen;
   logic [CNT_W-1:0]   cnt;
   logic [FRAME_W-2:0] rx_shift;
   logic [DATA_W-1:0]  tx_shift;

   // Command FSM with bit counter and both shift registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         phase        <= PH_FRAME;
         miso         <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rd_addr_seen <= 1'b0;
         cnt          <= '0;
         rx_shift     <= '0;
         tx_shift     <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (ss_n) begin
            state    <= IDLE;
            phase    <= PH_FRAME;
            miso     <= 1'b0;
            cnt      <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state <= CHK_CMD;
               end
               CHK_CMD: begin
                  phase    <= PH_FRAME;
                  cnt      <= '0;
                  rx_shift <= '0;
                  if (!mosi)
                     state <= WRITE;
                  else if (rd_addr_seen)
                     state <= READ_DATA;
                  else
                     state <= READ_ADD;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  case (phase)
                     PH_FRAME: begin
                        rx_shift <= {rx_shift[FRAME_W-3:0], mosi};
                        if (cnt == CNT_W'(FRAME_W - 1)) begin
                           rx_data  <= {rx_shift, mosi};
                           rx_valid <= 1'b1;
                           cnt      <= '0;
                           if (state == READ_ADD)
                              rd_addr_seen <= 1'b1;
                           phase <= (state == READ_DATA) ? PH_RXV : PH_HOLD;
                        end else begin
                           cnt <= cnt + 1'b1;
                        end
                     end
                     // Two dead cycles so a tx_valid left high by the previous read is ignored.
                     PH_RXV:   phase <= PH_GUARD;
                     PH_GUARD: phase <= PH_WAIT_TX;
                     PH_WAIT_TX: begin
                        if (tx_valid) begin
                           tx_shift <= tx_data;
                           cnt      <= '0;
                           phase    <= PH_SHIFT;
                        end
                     end
                     PH_SHIFT: begin
                        if (cnt == CNT_W'(DATA_W)) begin
                           miso         <= 1'b0;
                           rd_addr_seen <= 1'b0;
                           phase        <= PH_HOLD;
                        end else begin
                           miso     <= tx_shift[DATA_W-1];
                           tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                           cnt      <= cnt + 1'b1;
                        end
                     end
                     default: begin
                        phase <= PH_HOLD;
                     end
                  endcase
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Randomised scoreboard bench for spi_slave with a behavioural RAM model.
module tb_spi_slave;
   import spi_pkg::*;

   localparam int unsigned FW = FRAME_W_DEF;
   localparam int unsigned DW = DATA_W_DEF;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          ss_n     = 1'b1;
   logic          mosi     = 1'b0;
   logic          tx_valid = 1'b0;
   logic [DW-1:0] tx_data  = '0;
   logic          miso;
   logic          rx_valid;
   logic [FW-1:0] rx_data;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   typedef struct {
      logic [FW-1:0] data;
      int            edge_n;
   } rx_exp_t;

   typedef struct {
      logic [DW-1:0] data;
      int            first;
   } tx_exp_t;

   rx_exp_t rx_q[$];
   tx_exp_t tx_q[$];

   // Reference model state: RAM contents/pointers and the read-address flag.
   logic [7:0]    mem [256];
   logic [7:0]    wr_addr = '0;
   logic [7:0]    rd_addr = '0;
   bit            seen_m  = 1'b0;
   logic [FW-1:0] last_rx = '0;

   spi_slave #(.FRAME_W(FW), .DATA_W(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ss_n     (ss_n),
      .mosi     (mosi),
      .miso     (miso),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic void ram_apply(input logic [FW-1:0] f);
      case (f[9:8])
         OP_WR_ADDR: wr_addr = f[7:0];
         OP_WR_DATA: mem[wr_addr] = f[7:0];
         OP_RD_ADDR: rd_addr = f[7:0];
         default: ;
      endcase
   endfunction

   // Monitor: frames on rx_valid, and miso against expected byte windows.
   always @(posedge clk) begin
      rx_exp_t       e;
      logic          exp_bit;
      logic [DW-1:0] b;
      int            idx;
      #1;
      if (rst_n) begin
         if (rx_q.size() > 0 && rx_q[0].edge_n < cyc) begin
            vectors++;
            errors++;
            $display("FAIL rx_missing exp=%h at edge %0d", rx_q[0].data, rx_q[0].edge_n);
            void'(rx_q.pop_front());
         end
         if (rx_valid) begin
            vectors++;
            if (rx_q.size() == 0) begin
               errors++;
               $display("FAIL rx_unexpected got=%h at edge %0d", rx_data, cyc);
            end else begin
               e = rx_q.pop_front();
               if (e.data !== rx_data || e.edge_n != cyc) begin
                  errors++;
                  $display("FAIL rx_frame got=%h@%0d exp=%h@%0d", rx_data, cyc, e.data, e.edge_n);
               end
            end
         end
         exp_bit = 1'b0;
         if (tx_q.size() > 0 && cyc >= tx_q[0].first && cyc < tx_q[0].first + 8) begin
            b       = tx_q[0].data;
            idx     = cyc - tx_q[0].first;
            exp_bit = b[7-idx];
         end
         vectors++;
         if (miso !== exp_bit) begin
            errors++;
            $display("FAIL miso got=%b exp=%b at edge %0d", miso, exp_bit, cyc);
         end
         if (tx_q.size() > 0 && cyc == tx_q[0].first + 7)
            void'(tx_q.pop_front());
      end
   end

   // One transaction: op bit plus frame; optional ss_n abort after abort_at frame bits.
   task automatic xfer(input logic op, input logic [FW-1:0] frame, input int abort_at, input bit stale);
      int         a;
      int         d;
      int         lat;
      int         stop;
      logic [7:0] rdat;
      bit         rd_data;
      @(negedge clk);
      rd_data = (op == 1'b1) && seen_m;
      if (rd_data && stale) begin
         tx_data  = 8'hFF;
         tx_valid = 1'b1;
      end else if (rd_data) begin
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
      end
      ss_n = 1'b0;
      mosi = 1'($urandom);
      a    = cyc + 1;
      if (abort_at < 0)
         rx_q.push_back('{data: frame, edge_n: a + 11});
      @(negedge clk);
      mosi = op;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == abort_at) begin
            ss_n = 1'b1;
            return;
         end
         mosi = frame[9-i];
      end
      last_rx = frame;
      ram_apply(frame);
      if (!rd_data) begin
         if (op) seen_m = 1'b1;
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            mosi = 1'($urandom);
         end
         @(negedge clk);
         ss_n = 1'b1;
      end else begin
         rdat = mem[rd_addr];
         d    = stale ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 5));
         lat  = (12 + d > 14) ? 12 + d : 14;
         tx_q.push_back('{data: rdat, first: a + lat + 1});
         stop = a + lat + 9 + int'($urandom_range(0, 3));
         while (cyc < stop) begin
            @(negedge clk);
            mosi = 1'($urandom);
            if (cyc == a + 11 + d) begin
               tx_data  = rdat;
               tx_valid = 1'b1;
            end
         end
         seen_m = 1'b0;
         @(negedge clk);
         ss_n = 1'b1;
         if ($urandom_range(0, 1) == 0) tx_valid = 1'b0;
      end
   endtask

   // Assert reset during the sixth frame bit and check outputs drop at once.
   task automatic reset_mid(input logic op);
      @(negedge clk);
      ss_n = 1'b0;
      mosi = 1'b0;
      @(negedge clk);
      mosi = op;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mosi = 1'($urandom);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_rx_valid", 32'(rx_valid), 32'd0);
      chk("rstmid_miso", 32'(miso), 32'd0);
      chk("rstmid_rx_data", 32'(rx_data), 32'd0);
      rx_q.delete();
      tx_q.delete();
      seen_m  = 1'b0;
      last_rx = '0;
      ss_n    = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic          op;
      logic [1:0]    fop;
      logic [FW-1:0] saved;
      int            ab;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_rx_valid", 32'(rx_valid), 32'd0);
      chk("reset_miso", 32'(miso), 32'd0);
      chk("reset_rx_data", 32'(rx_data), 32'd0);

      // Write address 0xA5, then write data 0x3C there.
      xfer(1'b0, 10'h0A5, -1, 1'b0);
      xfer(1'b0, 10'h13C, -1, 1'b0);
      // Read address then read data -> 0x3C on miso.
      xfer(1'b1, 10'h2A5, -1, 1'b0);
      xfer(1'b1, 10'h300, -1, 1'b0);
      // Stale tx_valid=1/0xFF held while the RAM returns 0x81.
      xfer(1'b0, 10'h042, -1, 1'b0);
      xfer(1'b0, 10'h181, -1, 1'b0);
      xfer(1'b1, 10'h242, -1, 1'b0);
      xfer(1'b1, 10'h300, -1, 1'b1);
      // Read-data opcode without a prior read address takes the address path.
      xfer(1'b1, 10'h3C3, -1, 1'b0);
      xfer(1'b1, 10'h300, -1, 1'b0);
      // Abort after six frame bits, then a full frame.
      saved = last_rx;
      xfer(1'b0, 10'h0B7, 6, 1'b0);
      @(negedge clk);
      chk("abort_rx_data_held", 32'(rx_data), 32'(saved));
      xfer(1'b0, 10'h011, -1, 1'b0);
      // Reset mid-frame with the read-address flag set; it must clear.
      xfer(1'b1, 10'h2A5, -1, 1'b0);
      reset_mid(1'b1);
      xfer(1'b1, 10'h2A5, -1, 1'b0);
      xfer(1'b1, 10'h300, -1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         op = 1'($urandom);
         if (!op)       fop = {1'b0, 1'($urandom)};
         else if (seen_m) fop = OP_RD_DATA;
         else           fop = OP_RD_ADDR;
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
         xfer(op, {fop, 8'($urandom)}, ab, 1'($urandom));
      end

      repeat (5) @(negedge clk);
      chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);
      chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
